fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//   Fetch stage front end with an instruction prefetch queue, sitting directly upstream of the F/D buffer.
//   - Owns the PC. Issues word reads to instruction memory over a single-outstanding req/valid handshake.
//   - Queues returned instructions and presents one per cycle to decode.
//   - Absorbs decode stalls and redirects (branch/flush) without losing or duplicating instructions.
// PARAMETERS
//   W        16  instruction width
//   PC_W     32  program counter width
//   DEPTH    4   prefetch queue entries (power of 2, >=2)
//   RESET_PC 0   PC value loaded on reset
// PORTS
//   clk          in   1      clock; all state updates on rising edge
//   rst          in   1      asynchronous, active-low reset
//   imem_req     out  1      read request strobe (one cycle per request)
//   imem_addr    out  PC_W   word address of request; valid while imem_req=1
//   imem_valid   in   1      read data return strobe
//   imem_rdata   in   W      returned instruction; valid while imem_valid=1
//   stall        in   1      decode cannot accept this cycle
//   redirect     in   1      flush queue and restart fetch at redirect_pc
//   redirect_pc  in   PC_W   new fetch address
//   instr        out  W      instruction to F/D buffer; NOP when instr_valid=0
//   instr_pc     out  PC_W   PC of instr; 0 when instr_valid=0
//   instr_valid  out  1      instr is a real fetched instruction
// BEHAVIOUR
//   Reset (rst=0, async):
//   - pc=RESET_PC; queue empty; FSM=IDLE; epoch=0.
//   - Outputs: imem_req=0, instr=NOP (16'b0000010000110000), instr_pc=0, instr_valid=0.
//   Request FSM (registered):
//   - IDLE -> WAIT when count+0 < DEPTH and redirect=0.
//     - Drives imem_req=1, imem_addr=pc. On that edge: pc<=pc+1, req_epoch<=epoch.
//   - WAIT -> IDLE on imem_valid=1. imem_req=0 throughout WAIT (max one outstanding request).
//   - imem_valid in IDLE is a protocol error: ignore it; the bench flags it.
//   Queue push:
//   - Push on imem_valid in WAIT when req_epoch==epoch and redirect=0.
//   - Entry = {imem_rdata, pc_of_request}.
//   - Occupancy + outstanding never exceeds DEPTH, so a push never overflows.
//   Queue pop:
//   - instr_valid = (count!=0) & ~redirect. instr/instr_pc are combinational from the head.
//   - Pop when instr_valid & ~stall. Push and pop in the same cycle leave count unchanged.
//   Latency:
//   - imem_req at cycle t, imem_valid at t+k (k>=1) -> instr_valid at t+k+1 if the queue was empty.
//   - Reset release to first instr_valid is 2 cycles with k=1.
//   Redirect (wins over all simultaneous events):
//   - On the edge: queue cleared (count=0), pc<=redirect_pc, epoch toggles.
//   - Same cycle: no pop, instr_valid=0, no new imem_req.
//   - A response still in flight returns with the stale epoch, is dropped, and FSM -> IDLE.
//   - If the stale response returns in the redirect cycle itself, it is also dropped.
//   Stall:
//   - Holds head stable. Fetch continues until the queue is full.
//   Wrap: pc increments modulo 2^PC_W. Queue pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//   Reset mid-operation: immediate return to reset state; any outstanding response is ignored.
// STRUCTURE
//   Shared package/header:
//   - NOP_INSTR constant (16'b0000010000110000).
//   - W and PC_W defaults.
//   - FSM state encoding (IDLE=1'b0, WAIT=1'b1).
//   Sub-module: fetch_queue_fifo
//   - Parameters: DEPTH, width W+PC_W.
//   - Ports: push, pop, clear, din, dout, count, full, empty.
//   Top level holds the PC register, epoch bit, request FSM and output muxing.
// TESTING
//   1. Reset release, stall=0, memory k=1, rdata=addr+16'h100:
//      -> instr_valid first high 2 cycles later with instr=16'h0100, instr_pc=0; then one instr per 2 cycles.
//   2. stall=1 held for 12 cycles:
//      -> exactly 4 queued; imem_req stays 0 after the 4th; head stable.
//      -> On release: pcs 0,1,2,3 in consecutive cycles.
//   3. redirect to pc=0x40 while a request is outstanding, response returns next cycle:
//      -> response dropped; next imem_addr=0x40; first instr_pc after redirect=0x40.
//   4. redirect in the same cycle as imem_valid and a pop:
//      -> no pop, no push, count=0 next cycle, instr_valid=0 that cycle.
//   5. redirect_pc=32'hFFFFFFFF, stall=0:
//      -> instr_pc sequence FFFFFFFF, 00000000, 00000001.
//   6. Assert rst=0 mid-fetch with a full queue, then release:
//      -> outputs at reset values immediately (async); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit_pkg.sv
// rtl/fetch_prefetch_unit_pkg.sv - shared constants and FSM encoding for the fetch front end
package fetch_prefetch_unit_pkg;

  localparam int W_DEF    = 16;
  localparam int PC_W_DEF = 32;

  localparam logic [15:0] NOP_INSTR = 16'b0000010000110000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - prefetch queue holding {instruction, pc} entries
module fetch_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - fetch front end: PC, single-outstanding request FSM, prefetch queue
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int              W        = W_DEF,
  parameter int              PC_W     = PC_W_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [W-1:0]    imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [W-1:0]    instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid
);

  localparam int DW = W + PC_W;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            epoch_q;
  logic            req_epoch_q;

  logic            can_fetch;
  logic            push;
  logic            pop;
  logic [DW-1:0]   head;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;

  // In IDLE nothing is outstanding, so queue occupancy alone bounds the next request.
  assign can_fetch = (state_q == ST_IDLE) && (q_count < CW'(DEPTH)) && !redirect;
  assign imem_req  = rst && can_fetch;
  assign imem_addr = pc_q;

  // A response tagged with an old epoch belongs to a flushed stream and is discarded.
  assign push        = (state_q == ST_WAIT) && imem_valid && (req_epoch_q == epoch_q)
                       && !redirect && !q_full;
  assign instr_valid = !q_empty && !redirect;
  assign pop         = instr_valid && !stall;

  fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   ({imem_rdata, req_pc_q}),
    .dout  (head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign instr    = instr_valid ? head[DW-1 -: W]   : W'(NOP_INSTR);
  assign instr_pc = instr_valid ? head[PC_W-1:0]    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
    end else begin
      if (redirect) begin
        pc_q    <= redirect_pc;
        epoch_q <= ~epoch_q;
      end else if (can_fetch) begin
        pc_q        <= pc_q + PC_W'(1);
        req_pc_q    <= pc_q;
        req_epoch_q <= epoch_q;
      end
      case (state_q)
        ST_IDLE: if (can_fetch)  state_q <= ST_WAIT;
        ST_WAIT: if (imem_valid) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [15:0] NOP   = 16'h0430;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .W        (16),
    .PC_W     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] data;
  } ent_t;

  typedef struct {
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  ent_t        mq[$];
  logic [31:0] mnpc = '0;
  bit          pend = 0;
  bit          pend_killed = 0;
  int          pend_delay = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_mpc = '0;
  int          k_lat = 1;

  bit          auto_redir = 0;
  bit          auto_hit = 0;
  logic [31:0] auto_pc = '0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;
  logic [15:0] s_instr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_data(input logic [31:0] a);
    return a[15:0] + 16'h0100;
  endfunction

  // One clock cycle: drive inputs, act as memory, compare against the queue model, advance it.
  task automatic do_cycle(input bit st, input bit rd, input logic [31:0] rpc);
    bit          exp_valid, exp_req;
    logic [15:0] exp_instr;
    logic [31:0] exp_pc;
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    if (pend) begin
      pend_delay--;
      if (pend_delay <= 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_data(pend_addr);
      end
    end
    if (auto_redir && imem_valid && mq.size() > 0 && !stall) begin
      redirect    = 1'b1;
      redirect_pc = auto_pc;
      auto_redir  = 0;
      auto_hit    = 1;
    end
    #1;
    exp_valid = (mq.size() != 0) && !redirect;
    exp_req   = !pend && (mq.size() < DEPTH) && !redirect;
    exp_instr = exp_valid ? mq[0].data : NOP;
    exp_pc    = exp_valid ? mq[0].pc : 32'h0;
    check("instr_valid", instr_valid, exp_valid);
    check("instr", instr, exp_instr);
    check("instr_pc", instr_pc, exp_pc);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, mnpc);
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = instr_pc; s_instr = instr;

    if (exp_valid && !stall) void'(mq.pop_front());
    if (imem_valid) begin
      if (!pend_killed && !redirect) mq.push_back('{pend_mpc, mem_data(pend_mpc)});
      pend = 0;
    end
    if (redirect) begin
      mq.delete();
      mnpc = redirect_pc;
      if (pend) pend_killed = 1;
    end else if (imem_req) begin
      pend        = 1;
      pend_killed = 0;
      pend_delay  = k_lat;
      pend_addr   = imem_addr;
      pend_mpc    = mnpc;
      mnpc        = mnpc + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'h0);
    mq.delete();
    pend = 0; pend_killed = 0; mnpc = 32'h0;
    stall = 0; redirect = 0; redirect_pc = '0; imem_valid = 0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    bit          found, ga, gv;
    int          nreq, ncol;
    logic [31:0] a, p;
    logic [31:0] pcs[3];

    vecs[0] = '{0, 1, 32'h0, 0, 32'h0, NOP};
    vecs[1] = '{0, 0, 32'h0, 0, 32'h0, NOP};
    vecs[2] = '{0, 1, 32'h1, 1, 32'h0, 16'h0100};
    vecs[3] = '{0, 0, 32'h0, 0, 32'h0, NOP};
    vecs[4] = '{0, 1, 32'h2, 1, 32'h1, 16'h0101};
    vecs[5] = '{0, 0, 32'h0, 0, 32'h0, NOP};
    vecs[6] = '{0, 1, 32'h3, 1, 32'h2, 16'h0102};

    // Test 1: latency table after reset release, k=1
    k_lat = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_cycle(vecs[i].stall, 0, 32'h0);
      check($sformatf("t1_req[%0d]", i), s_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("t1_addr[%0d]", i), s_addr, vecs[i].exp_addr);
      check($sformatf("t1_valid[%0d]", i), s_valid, vecs[i].exp_valid);
      check($sformatf("t1_pc[%0d]", i), s_pc, vecs[i].exp_pc);
      check($sformatf("t1_instr[%0d]", i), s_instr, vecs[i].exp_instr);
    end

    // Test 2: stall from reset fills exactly DEPTH entries
    do_reset();
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      do_cycle(1, 0, 32'h0);
      if (s_req) nreq++;
    end
    check("t2_req_count", nreq, DEPTH);
    check("t2_head_valid", s_valid, 1'b1);
    check("t2_head_pc", s_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 0, 32'h0);
      check($sformatf("t2_drain_valid[%0d]", i), s_valid, 1'b1);
      check($sformatf("t2_drain_pc[%0d]", i), s_pc, i);
    end

    // Test 3: redirect while a request is outstanding
    k_lat = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle(0, 0, 32'h0);
      if (s_req) found = 1;
    end
    check("t3_req_seen", found, 1'b1);
    do_cycle(0, 1, 32'h40);
    ga = 0; gv = 0; a = '0; p = '0;
    for (int i = 0; i < 20; i++) begin
      do_cycle(0, 0, 32'h0);
      if (s_req && !ga) begin ga = 1; a = s_addr; end
      if (s_valid && !gv) begin gv = 1; p = s_pc; end
    end
    check("t3_first_addr", ga ? a : 32'hDEAD_BEEF, 32'h40);
    check("t3_first_pc", gv ? p : 32'hDEAD_BEEF, 32'h40);

    // Test 4: redirect coinciding with a response and a pop
    k_lat = 1;
    repeat (6) do_cycle(1, 0, 32'h0);
    auto_pc = 32'h80; auto_hit = 0; auto_redir = 1;
    for (int i = 0; i < 20 && !auto_hit; i++) do_cycle(0, 0, 32'h0);
    auto_redir = 0;
    check("t4_hit", auto_hit, 1'b1);
    check("t4_valid_in_redirect", s_valid, 1'b0);
    do_cycle(0, 0, 32'h0);
    check("t4_valid_after", s_valid, 1'b0);
    check("t4_req_after", s_req, 1'b1);
    check("t4_addr_after", s_addr, 32'h80);

    // Test 5: PC wrap
    do_cycle(0, 1, 32'hFFFF_FFFF);
    ncol = 0;
    for (int i = 0; i < 30 && ncol < 3; i++) begin
      do_cycle(0, 0, 32'h0);
      if (s_valid) begin pcs[ncol] = s_pc; ncol++; end
    end
    check("t5_count", ncol, 3);
    check("t5_pc0", (ncol > 0) ? pcs[0] : 32'h1234, 32'hFFFF_FFFF);
    check("t5_pc1", (ncol > 1) ? pcs[1] : 32'h1234, 32'h0000_0000);
    check("t5_pc2", (ncol > 2) ? pcs[2] : 32'h1234, 32'h0000_0001);

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      k_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 99) < 4)
        do_cycle($urandom_range(0, 9) < 3, 1,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom));
      else
        do_cycle($urandom_range(0, 9) < 3, 0, 32'h0);
    end

    // Test 6: reset mid-operation with a full queue
    k_lat = 1;
    repeat (12) do_cycle(1, 0, 32'h0);
    check("t6_full_no_req", s_req, 1'b0);
    check("t6_full_valid", s_valid, 1'b1);
    do_reset();
    ga = 0; gv = 0; a = '0; p = '0;
    for (int i = 0; i < 10; i++) begin
      do_cycle(0, 0, 32'h0);
      if (s_req && !ga) begin ga = 1; a = s_addr; end
      if (s_valid && !gv) begin gv = 1; p = s_pc; end
    end
    check("t6_first_addr", ga ? a : 32'hDEAD_BEEF, 32'h0);
    check("t6_first_pc", gv ? p : 32'hDEAD_BEEF, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
